// File: rtl/shifter_pkg.sv
// Shared constants and elaboration helpers for the barrel shifter family.
package shifter_pkg;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  // Smallest r with 2**r >= n; usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One registered level of the right barrel shifter: conditional shift by DIST
// with sign/zero fill, plus a skid-free valid/ready stage register.
module right_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_shamt,
  input  logic             up_arith,
  input  logic             up_sign,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [SHW-1:0]   dn_shamt,
  output logic             dn_arith,
  output logic             dn_sign
);

  localparam int BIT = clog2(DIST);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   shamt_q;
  logic             arith_q;
  logic             sign_q;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  assign fill    = (up_arith == SHIFT_ARITH) ? up_sign : SHIFT_LOGICAL;
  assign shifted = up_shamt[BIT] ? {{DIST{fill}}, up_data[WIDTH-1:DIST]} : up_data;

  // Handshake: a beat moves across a boundary when valid & ready are both high
  // at a rising edge; this stage is ready whenever it is empty or its own beat
  // leaves this cycle, so an empty stage fills even while downstream stalls.
  assign up_ready = ~valid_q | dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q  <= shifted;
        shamt_q <= up_shamt;
        arith_q <= up_arith;
        sign_q  <= up_sign;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_shamt = shamt_q;
  assign dn_arith = arith_q;
  assign dn_sign  = sign_q;

endmodule

// File: rtl/right_barrel_shifter_pipe.sv
// Pipelined logical/arithmetic right barrel shifter, one register stage per
// shift level (stage k shifts by 2**k), valid/ready with bubble collapsing.
module right_barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEVELS = clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_arith,
  input  logic [LEVELS-1:0] in_shamt,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  if (!is_pow2(WIDTH)) begin : g_bad_width
    $error("right_barrel_shifter_pipe: WIDTH must be a power of two >= 2");
  end

  // Index 0 is the input port; index k+1 is the output of stage k.
  logic              v [0:LEVELS];
  logic              r [0:LEVELS];
  logic [WIDTH-1:0]  d [0:LEVELS];
  logic [LEVELS-1:0] s [0:LEVELS];
  logic              a [0:LEVELS];
  logic              g [0:LEVELS];
  logic              unused_tail;

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign s[0]      = in_shamt;
  assign a[0]      = in_arith;
  assign g[0]      = in_data[WIDTH-1];
  assign in_ready  = r[0];
  assign r[LEVELS] = out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    right_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .SHW   (LEVELS)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[k]),
      .up_ready (r[k]),
      .up_data  (d[k]),
      .up_shamt (s[k]),
      .up_arith (a[k]),
      .up_sign  (g[k]),
      .dn_valid (v[k+1]),
      .dn_ready (r[k+1]),
      .dn_data  (d[k+1]),
      .dn_shamt (s[k+1]),
      .dn_arith (a[k+1]),
      .dn_sign  (g[k+1])
    );
  end

  // Shift control is fully consumed by the last stage.
  assign unused_tail = ^{s[LEVELS], a[LEVELS], g[LEVELS]};

  assign out_valid = v[LEVELS];
  assign out_data  = v[LEVELS] ? d[LEVELS] : '0;

endmodule

// File: tb/tb_right_barrel_shifter_pipe.sv
// Directed and random checks for right_barrel_shifter_pipe (WIDTH 32).
module tb_right_barrel_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_arith;
  logic [4:0]  in_shamt;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  right_barrel_shifter_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_arith  (in_arith),
    .in_shamt  (in_shamt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
    if (a) return $unsigned($signed(d) >>> s);
    return d >> s;
  endfunction

  // Drive one beat with out_ready=1 and wait for its result.
  task automatic run_one(input logic [31:0] d, input logic [4:0] s, input logic a,
                         output logic [31:0] res, output int lat, output bit ok);
    res = '0; lat = 0; ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_arith = a; out_ready = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (out_valid) begin
        res = out_data; lat = i; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_arith = 1'b0; in_shamt = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_logical();
    logic [31:0] res; int lat; bit ok;
    run_one(32'h8000_0000, 5'd4, 1'b0, res, lat, ok);
    checks++; if (!ok || res !== 32'h0800_0000) begin failures++; $display("FAIL logical_8000_s4 got=%h exp=08000000 seen=%0d", res, ok); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL logical_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_arith();
    logic [31:0] res; int lat; bit ok;
    run_one(32'h8000_0000, 5'd4, 1'b1, res, lat, ok);
    checks++; if (!ok || res !== 32'hF800_0000) begin failures++; $display("FAIL arith_8000_s4 got=%h exp=f8000000", res); end
    run_one(32'h8000_0000, 5'd31, 1'b1, res, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL arith_8000_s31 got=%h exp=ffffffff", res); end
    run_one(32'h7FFF_FFFF, 5'd31, 1'b1, res, lat, ok);
    checks++; if (!ok || res !== 32'h0000_0000) begin failures++; $display("FAIL arith_7fff_s31 got=%h exp=00000000", res); end
  endtask

  task automatic test_boundary();
    logic [31:0] res; int lat; bit ok;
    run_one(32'h1234_5678, 5'd0, 1'b0, res, lat, ok);
    checks++; if (!ok || res !== 32'h1234_5678) begin failures++; $display("FAIL pass_logical got=%h exp=12345678", res); end
    run_one(32'h1234_5678, 5'd0, 1'b1, res, lat, ok);
    checks++; if (!ok || res !== 32'h1234_5678) begin failures++; $display("FAIL pass_arith got=%h exp=12345678", res); end
    run_one(32'hDEAD_BEEF, 5'd16, 1'b0, res, lat, ok);
    checks++; if (!ok || res !== 32'h0000_DEAD) begin failures++; $display("FAIL dead_s16 got=%h exp=0000dead", res); end
    run_one(32'h8000_0000, 5'd31, 1'b0, res, lat, ok);
    checks++; if (!ok || res !== 32'h0000_0001) begin failures++; $display("FAIL logical_s31 got=%h exp=00000001", res); end
    run_one(32'hF000_0000, 5'd0, 1'b1, res, lat, ok);
    checks++; if (!ok || res !== 32'hF000_0000) begin failures++; $display("FAIL pass_neg_arith got=%h exp=f0000000", res); end
  endtask

  task automatic test_backpressure();
    logic [31:0] vd [8];
    logic [4:0]  vs [8];
    logic        va [8];
    int sent, got, last_out;
    bit have_held;
    logic [31:0] held, e;
    vd = '{32'h8000_0000, 32'hDEAD_BEEF, 32'hF0F0_F0F0, 32'h1234_5678,
           32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0100};
    vs = '{5'd4, 5'd16, 5'd7, 5'd0, 5'd31, 5'd1, 5'd30, 5'd8};
    va = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sent = 0; got = 0; last_out = -10; have_held = 1'b0; held = '0;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (sent < 8);
      if (sent < 8) begin in_data = vd[sent]; in_shamt = vs[sent]; in_arith = va[sent]; end
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_shift(in_data, in_shamt, in_arith)); sent++; end
      if (out_valid) begin
        if (!have_held) begin held = out_data; have_held = 1'b1; end
        else begin
          checks++;
          if (out_data !== held) begin failures++; $display("FAIL stall_stable got=%h exp=%h", out_data, held); end
        end
      end
    end
    checks++; if (sent !== 5) begin failures++; $display("FAIL stall_accepts got=%0d exp=5", sent); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 8);
      if (sent < 8) begin in_data = vd[sent]; in_shamt = vs[sent]; in_arith = va[sent]; end
      #1;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (out_data !== e) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", got, out_data, e); end
        if (got > 0) begin
          checks++;
          if (c !== last_out + 1) begin failures++; $display("FAIL bp_gap beat%0d cycle=%0d exp=%0d", got, c, last_out + 1); end
        end
        last_out = c; got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_shift(in_data, in_shamt, in_arith)); sent++; end
    end
    checks++; if (got !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_bubble();
    int got, first_c;
    got = 0; first_c = -10;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hCAFE_F00D; in_shamt = 5'd12; in_arith = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_accept_a got=%b exp=1", in_ready); end
    repeat (4) begin @(negedge clk); in_valid = 1'b0; end
    in_valid = 1'b1; in_data = 32'h9000_0000; in_shamt = 5'd3; in_arith = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_accept_b got=%b exp=1", in_ready); end
    repeat (8) begin @(negedge clk); in_valid = 1'b0; end
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready_idle got=%b exp=1", in_ready); end
    checks++; if (out_data !== 32'h000C_AFEF) begin failures++; $display("FAIL bubble_held_a got=%h exp=000cafef", out_data); end
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (got == 0) begin
          checks++;
          if (out_data !== 32'h000C_AFEF) begin failures++; $display("FAIL bubble_out_a got=%h exp=000cafef", out_data); end
          first_c = c;
        end else begin
          checks++;
          if (out_data !== 32'hF200_0000) begin failures++; $display("FAIL bubble_out_b got=%h exp=f2000000", out_data); end
          checks++;
          if (c !== first_c + 1) begin failures++; $display("FAIL bubble_b_adjacent cycle=%0d exp=%0d", c, first_c + 1); end
        end
        got++;
      end
    end
    checks++; if (got !== 2) begin failures++; $display("FAIL bubble_count got=%0d exp=2", got); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0000 + 32'(c); in_shamt = 5'(c); in_arith = 1'b1;
    end
    repeat (4) begin @(negedge clk); in_valid = 1'b0; end
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL midrst_out_data got=%h exp=00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_stale_emits got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    int sent, got, n;
    bit pending, prev_stall;
    logic [31:0] prev_data, e;
    n = 10000; sent = 0; got = 0; pending = 1'b0; prev_stall = 1'b0; prev_data = '0;
    exp_q.delete();
    for (int c = 0; c < 60000 && got < n; c++) begin
      @(negedge clk);
      if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        in_data = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_arith = 1'($urandom_range(0, 1));
      end
      in_valid = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin failures++; $display("FAIL rand_stall_hold cycle=%0d got=%h exp=%h", c, out_data, prev_data); end
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== 32'h0) begin failures++; $display("FAIL rand_idle_zero cycle=%0d got=%h exp=00000000", c, out_data); end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (out_data !== e) begin failures++; $display("FAIL rand_beat%0d got=%h exp=%h", got, out_data, e); end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_shamt, in_arith));
        sent++; pending = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
    checks++; if (got !== n) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got, n); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_boundary();
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
